// File: rtl/decode_if.sv
// Decode-stage bus: fetch handshake, register-file read ports, micro-op handshake and flush.
// Modports: slave is the decode stage, master is its environment.
interface decode_if;
  logic        flush_i;
  logic        input_valid_i;
  logic        input_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic [4:0]  reg_raddr1_o;
  logic [4:0]  reg_raddr2_o;
  logic [31:0] reg_rdata1_i;
  logic [31:0] reg_rdata2_i;
  logic        output_valid_o;
  logic        output_ready_i;
  logic [2:0]  class_o;
  logic [2:0]  alu_op_o;
  logic        alu_alt_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [31:0] imm_o;
  logic [31:0] rs2_data_o;
  logic [4:0]  rd_o;
  logic        reg_write_o;
  logic [31:0] pc_o;

  modport slave (
    input  flush_i, input_valid_i, instr_i, pc_i, reg_rdata1_i, reg_rdata2_i, output_ready_i,
    output input_ready_o, reg_raddr1_o, reg_raddr2_o, output_valid_o, class_o, alu_op_o,
    output alu_alt_o, op1_o, op2_o, imm_o, rs2_data_o, rd_o, reg_write_o, pc_o
  );

  modport master (
    output flush_i, input_valid_i, instr_i, pc_i, reg_rdata1_i, reg_rdata2_i, output_ready_i,
    input  input_ready_o, reg_raddr1_o, reg_raddr2_o, output_valid_o, class_o, alu_op_o,
    input  alu_alt_o, op1_o, op2_o, imm_o, rs2_data_o, rd_o, reg_write_o, pc_o
  );
endinterface

// File: rtl/decode.sv
// RV32I decode stage: 1-cycle registered micro-op, valid/ready on both sides, flush drops in-flight work.
// Optional 1-entry skid buffer (registered input ready) under DECODE_SKID_BUFFER_EN.
module decode #(
  parameter logic ILLEGAL_FLAG_EN_DEFAULT = 1'b1
) (
  input logic     clk_i,
  input logic     rst_ni,
  decode_if.slave bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] CLS_ALU     = 3'd0;
  localparam logic [2:0] CLS_LOAD    = 3'd1;
  localparam logic [2:0] CLS_STORE   = 3'd2;
  localparam logic [2:0] CLS_BRANCH  = 3'd3;
  localparam logic [2:0] CLS_JAL     = 3'd4;
  localparam logic [2:0] CLS_JALR    = 3'd5;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  alu_op;
    logic        alu_alt;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] rs2_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic [31:0] pc;
  } uop_t;

  logic [31:0] instr;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  uop_t        dec;
  uop_t        out_q;
  logic        out_vld;
  logic        accept;
  logic        out_free;

  assign instr = bus.instr_i;
  assign bus.reg_raddr1_o = instr[19:15];
  assign bus.reg_raddr2_o = instr[24:20];

  // x0 reads as zero whatever the register file returns
  assign rs1_val = (instr[19:15] == 5'd0) ? 32'd0 : bus.reg_rdata1_i;
  assign rs2_val = (instr[24:20] == 5'd0) ? 32'd0 : bus.reg_rdata2_i;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    dec           = '0;
    dec.cls       = CLS_ALU;
    dec.alu_op    = instr[14:12];
    dec.op1       = rs1_val;
    dec.op2       = rs2_val;
    dec.rs2_data  = rs2_val;
    dec.rd        = instr[11:7];
    dec.pc        = bus.pc_i;
    case (instr[6:0])
      OPC_OP: begin
        dec.alu_alt   = instr[30];
        dec.reg_write = 1'b1;
      end
      OPC_OPIMM: begin
        dec.imm       = imm_i;
        dec.op2       = imm_i;
        dec.alu_alt   = (instr[14:12] == 3'b101) ? instr[30] : 1'b0;
        dec.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        dec.cls       = CLS_LOAD;
        dec.imm       = imm_i;
        dec.op2       = imm_i;
        dec.reg_write = 1'b1;
      end
      OPC_STORE: begin
        dec.cls = CLS_STORE;
        dec.imm = imm_s;
        dec.op2 = imm_s;
      end
      OPC_BRANCH: begin
        dec.cls = CLS_BRANCH;
        dec.imm = imm_b;
      end
      OPC_JAL: begin
        dec.cls       = CLS_JAL;
        dec.imm       = imm_j;
        dec.op1       = bus.pc_i;
        dec.op2       = imm_j;
        dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec.cls       = CLS_JALR;
        dec.imm       = imm_i;
        dec.op2       = imm_i;
        dec.reg_write = 1'b1;
      end
      OPC_LUI: begin
        dec.alu_op    = 3'b000;
        dec.imm       = imm_u;
        dec.op1       = 32'd0;
        dec.op2       = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        dec.alu_op    = 3'b000;
        dec.imm       = imm_u;
        dec.op1       = bus.pc_i;
        dec.op2       = imm_u;
        dec.reg_write = 1'b1;
      end
      OPC_MISC: begin
        dec.reg_write = 1'b0;
      end
      default: begin
        // SYSTEM, unknown opcodes and compressed encodings all land here
        dec.cls       = ILLEGAL_FLAG_EN_DEFAULT ? CLS_ILLEGAL : CLS_ALU;
        dec.reg_write = 1'b0;
      end
    endcase
    if (instr[11:7] == 5'd0) dec.reg_write = 1'b0;
  end

  assign out_free = !out_vld || bus.output_ready_i;
  assign accept   = bus.input_valid_i && bus.input_ready_o;

`ifdef DECODE_SKID_BUFFER_EN
  uop_t skid_q;
  logic skid_vld;

  assign bus.input_ready_o = rst_ni && !skid_vld;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_vld  <= 1'b0;
      out_q    <= '0;
      skid_vld <= 1'b0;
      skid_q   <= '0;
    end else if (bus.flush_i) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (out_free) begin
      if (skid_vld) begin
        // skid only fills while stalled, and ready is low while it is full
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else if (accept) begin
        out_q   <= dec;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (accept) begin
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end
`else
  assign bus.input_ready_o = rst_ni && out_free;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_vld <= 1'b0;
      out_q   <= '0;
    end else if (bus.flush_i) begin
      out_vld <= 1'b0;
    end else if (accept) begin
      out_q   <= dec;
      out_vld <= 1'b1;
    end else if (bus.output_ready_i) begin
      out_vld <= 1'b0;
    end
  end
`endif

  assign bus.output_valid_o = out_vld;
  assign bus.class_o        = out_q.cls;
  assign bus.alu_op_o       = out_q.alu_op;
  assign bus.alu_alt_o      = out_q.alu_alt;
  assign bus.op1_o          = out_q.op1;
  assign bus.op2_o          = out_q.op2;
  assign bus.imm_o          = out_q.imm;
  assign bus.rs2_data_o     = out_q.rs2_data;
  assign bus.rd_o           = out_q.rd;
  assign bus.reg_write_o    = out_q.reg_write;
  assign bus.pc_o           = out_q.pc;

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: hand-computed micro-ops, stall, flush, reset and illegal handling.
// A second instance with the illegal flag disabled shares the same stimulus.
module tb_decode;

  logic clk;
  logic rst_ni;
  int   checks;
  int   errors;

  decode_if bus ();
  decode_if bus2 ();

  decode #(.ILLEGAL_FLAG_EN_DEFAULT(1'b1)) dut  (.clk_i(clk), .rst_ni(rst_ni), .bus(bus.slave));
  decode #(.ILLEGAL_FLAG_EN_DEFAULT(1'b0)) dut2 (.clk_i(clk), .rst_ni(rst_ni), .bus(bus2.slave));

  assign bus2.flush_i        = bus.flush_i;
  assign bus2.input_valid_i  = bus.input_valid_i;
  assign bus2.instr_i        = bus.instr_i;
  assign bus2.pc_i           = bus.pc_i;
  assign bus2.reg_rdata1_i   = bus.reg_rdata1_i;
  assign bus2.reg_rdata2_i   = bus.reg_rdata2_i;
  assign bus2.output_ready_i = bus.output_ready_i;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
    bus.instr_i       = instr;
    bus.pc_i          = pc;
    bus.input_valid_i = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    bus.flush_i        = 1'b0;
    bus.input_valid_i  = 1'b0;
    bus.instr_i        = 32'd0;
    bus.pc_i           = 32'd0;
    bus.reg_rdata1_i   = 32'hDEADBEEF;
    bus.reg_rdata2_i   = 32'h12345678;
    bus.output_ready_i = 1'b1;

    tick();
    tick();
    check("rst_valid", {31'd0, bus.output_valid_o}, 32'd0);
    check("rst_class", {29'd0, bus.class_o}, 32'd0);
    check("rst_op1", bus.op1_o, 32'd0);
    check("rst_in_ready", {31'd0, bus.input_ready_o}, 32'd0);
    rst_ni = 1'b1;
    #1;
    check("idle_in_ready", {31'd0, bus.input_ready_o}, 32'd1);

    // ADDI x1,x0,5: rs1 is x0 so rdata1 must be ignored
    drive(32'h00500093, 32'h00001000);
    tick();
    bus.input_valid_i = 1'b0;
    check("addi_valid", {31'd0, bus.output_valid_o}, 32'd1);
    check("addi_class", {29'd0, bus.class_o}, 32'd0);
    check("addi_op1", bus.op1_o, 32'd0);
    check("addi_op2", bus.op2_o, 32'd5);
    check("addi_imm", bus.imm_o, 32'd5);
    check("addi_rd", {27'd0, bus.rd_o}, 32'd1);
    check("addi_wr", {31'd0, bus.reg_write_o}, 32'd1);
    check("addi_pc", bus.pc_o, 32'h00001000);

    // SUB x3,x1,x2
    bus.reg_rdata1_i = 32'd10;
    bus.reg_rdata2_i = 32'd3;
    drive(32'h402081B3, 32'h00001004);
    #1;
    check("sub_raddr1", {27'd0, bus.reg_raddr1_o}, 32'd1);
    check("sub_raddr2", {27'd0, bus.reg_raddr2_o}, 32'd2);
    tick();
    bus.input_valid_i = 1'b0;
    check("sub_alu_op", {29'd0, bus.alu_op_o}, 32'd0);
    check("sub_alt", {31'd0, bus.alu_alt_o}, 32'd1);
    check("sub_op1", bus.op1_o, 32'd10);
    check("sub_op2", bus.op2_o, 32'd3);
    check("sub_rd", {27'd0, bus.rd_o}, 32'd3);

    // BEQ x1,x2,-8
    drive(32'hFE208CE3, 32'h00001008);
    tick();
    bus.input_valid_i = 1'b0;
    check("beq_class", {29'd0, bus.class_o}, 32'd3);
    check("beq_imm", bus.imm_o, 32'hFFFFFFF8);
    check("beq_wr", {31'd0, bus.reg_write_o}, 32'd0);
    check("beq_op2", bus.op2_o, 32'd3);
    tick();
    check("drain_valid", {31'd0, bus.output_valid_o}, 32'd0);

    // LUI x1,0x12345 and SW x2,8(x1)
    drive(32'h123450B7, 32'h00002000);
    tick();
    check("lui_op1", bus.op1_o, 32'd0);
    check("lui_op2", bus.op2_o, 32'h12345000);
    check("lui_wr", {31'd0, bus.reg_write_o}, 32'd1);
    drive(32'h0020A423, 32'h00002004);
    tick();
    bus.input_valid_i = 1'b0;
    check("sw_class", {29'd0, bus.class_o}, 32'd2);
    check("sw_imm", bus.imm_o, 32'd8);
    check("sw_op1", bus.op1_o, 32'd10);
    check("sw_data", bus.rs2_data_o, 32'd3);
    check("sw_wr", {31'd0, bus.reg_write_o}, 32'd0);

    // Stall: A held for 3 cycles while B waits, then B follows
    drive(32'h00500093, 32'h00003000);
    tick();
    bus.output_ready_i = 1'b0;
    drive(32'h00700113, 32'h00003004);
    #1;
    check("stall_in_ready", {31'd0, bus.input_ready_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'd0, bus.output_valid_o}, 32'd1);
      check("stall_op2", bus.op2_o, 32'd5);
      check("stall_rd", {27'd0, bus.rd_o}, 32'd1);
      check("stall_pc", bus.pc_o, 32'h00003000);
      check("stall_in_ready2", {31'd0, bus.input_ready_o}, 32'd0);
    end
    bus.output_ready_i = 1'b1;
    #1;
    check("unstall_in_ready", {31'd0, bus.input_ready_o}, 32'd1);
    tick();
    bus.input_valid_i = 1'b0;
    check("b_valid", {31'd0, bus.output_valid_o}, 32'd1);
    check("b_op2", bus.op2_o, 32'd7);
    check("b_rd", {27'd0, bus.rd_o}, 32'd2);
    check("b_pc", bus.pc_o, 32'h00003004);

    // Flush overrides an accept in the same cycle
    drive(32'h00500093, 32'h00004000);
    tick();
    drive(32'h00700113, 32'h00004004);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.input_valid_i = 1'b0;
    check("flush_valid", {31'd0, bus.output_valid_o}, 32'd0);
    tick();
    check("flush_no_emit", {31'd0, bus.output_valid_o}, 32'd0);

    // Reset while stalled drops the held micro-op
    drive(32'h00500093, 32'h00005000);
    tick();
    bus.input_valid_i  = 1'b0;
    bus.output_ready_i = 1'b0;
    tick();
    check("prerst_valid", {31'd0, bus.output_valid_o}, 32'd1);
    rst_ni = 1'b0;
    tick();
    check("midrst_valid", {31'd0, bus.output_valid_o}, 32'd0);
    check("midrst_op2", bus.op2_o, 32'd0);
    check("midrst_rd", {27'd0, bus.rd_o}, 32'd0);
    check("midrst_wr", {31'd0, bus.reg_write_o}, 32'd0);
    check("midrst_pc", bus.pc_o, 32'd0);
    check("midrst_in_ready", {31'd0, bus.input_ready_o}, 32'd0);
    rst_ni = 1'b1;
    bus.output_ready_i = 1'b1;

    // All-zero word: illegal with the flag, NOP without
    drive(32'h00000000, 32'h00006000);
    tick();
    bus.input_valid_i = 1'b0;
    check("ill_valid", {31'd0, bus.output_valid_o}, 32'd1);
    check("ill_class", {29'd0, bus.class_o}, 32'd7);
    check("ill_wr", {31'd0, bus.reg_write_o}, 32'd0);
    check("nop_valid", {31'd0, bus2.output_valid_o}, 32'd1);
    check("nop_class", {29'd0, bus2.class_o}, 32'd0);
    check("nop_wr", {31'd0, bus2.reg_write_o}, 32'd0);

    // SYSTEM (ECALL) is also illegal
    drive(32'h00000073, 32'h00006004);
    tick();
    bus.input_valid_i = 1'b0;
    check("ecall_class", {29'd0, bus.class_o}, 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- RV32I decode stage, directly downstream of the instruction fetch stage.
- Accepts `{instr, pc}` over a valid/ready handshake and reads two register-file ports combinationally.
- Produces a registered, fully decoded micro-op (class, ALU op, operands, immediate, destination) for the execute stage over a second valid/ready handshake.
- Supports a pipeline flush on control-flow change.

Parameters:
- `ILLEGAL_FLAG_EN_DEFAULT`, 1, when 0 illegal encodings decode as NOP (class ALU, `reg_write_o`=0) instead of class ILLEGAL.

Ports:
- `clk_i` in 1: clock; all state updates on posedge.
- `rst_ni` in 1: reset, synchronous, active-low.
- `flush_i` in 1: branch/irq taken; discard in-flight work.
- `input_valid_i` in 1: fetch output valid.
- `input_ready_o` out 1: decode can accept.
- `instr_i` in 32: instruction word.
- `pc_i` in 32: address of `instr_i`.
- `reg_raddr1_o` out 5: `instr_i[19:15]`, combinational.
- `reg_raddr2_o` out 5: `instr_i[24:20]`, combinational.
- `reg_rdata1_i` in 32: register file read data, same cycle.
- `reg_rdata2_i` in 32: register file read data, same cycle.
- `output_valid_o` out 1: micro-op valid.
- `output_ready_i` in 1: execute accepts.
- `class_o` out 3: 0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JAL, 5 JALR, 7 ILLEGAL.
- `alu_op_o` out 3: funct3.
- `alu_alt_o` out 1: SUB/SRA select.
- `op1_o` out 32: first operand.
- `op2_o` out 32: second operand.
- `imm_o` out 32: sign-extended immediate.
- `rs2_data_o` out 32: store data.
- `rd_o` out 5: destination register.
- `reg_write_o` out 1: writeback enable.
- `pc_o` out 32: pc of the micro-op.

Behaviour:
- **Reset.** `rst_ni`=0 at posedge clears all of the following; `input_ready_o`=0 while `rst_ni`=0.
  - `output_valid_o`=0.
  - `class_o`=0, `alu_op_o`=0, `alu_alt_o`=0.
  - `op1_o`/`op2_o`/`imm_o`/`rs2_data_o`/`pc_o`=0.
  - `rd_o`=0, `reg_write_o`=0.
  - Reset mid-stall drops the held micro-op.
- **Input ready.** `input_ready_o` = `rst_ni` && (!`output_valid_o` || `output_ready_i`), combinational.
- **Accept and latency.** Accept = `input_valid_i` && `input_ready_o`. The decoded result is registered at that edge: 1-cycle latency, `output_valid_o`=1 next cycle.
- **Valid de-assertion.** Output handshake without a new accept: `output_valid_o`→0.
- **Back-to-back.** Throughput of 1 per cycle when `output_ready_i` is held high.
- **Stall.** `output_valid_o`=1 && `output_ready_i`=0: every output is held bit-stable; no accept.
- **Flush.**
  - `flush_i`=1 at posedge forces `output_valid_o`←0 and discards any instruction accepted in that cycle; data outputs may hold.
  - `flush_i` overrides a simultaneous accept.
- **Immediates.** I, S, B, U and J formats, sign-extended from bit 31; B/J have bit 0 = 0.
- **Register x0.** Address 0 on a read port forces the operand to 0 regardless of `reg_rdata*_i`.
- **Operand selection by opcode.**
  - OP: `op1`=rs1, `op2`=rs2, `alu_alt`=`instr[30]`.
  - OP-IMM: `op1`=rs1, `op2`=imm; `alu_alt`=`instr[30]` only for funct3=101, else 0.
  - LOAD: `op1`=rs1, `op2`=imm, class 1.
  - STORE: `op1`=rs1, `op2`=imm, `rs2_data`=rs2, class 2, `reg_write`=0.
  - BRANCH: `op1`=rs1, `op2`=rs2, `imm`=B-offset, class 3, `reg_write`=0.
  - JAL: `op1`=pc, `op2`=imm, class 4.
  - JALR: `op1`=rs1, `op2`=imm, class 5.
  - LUI: `op1`=0, `op2`=imm, `alu_op`=000, class 0.
  - AUIPC: `op1`=pc, `op2`=imm, `alu_op`=000, class 0.
  - MISC-MEM (FENCE): NOP (class 0, `reg_write`=0).
  - Any other opcode, SYSTEM, or `instr[1:0]`≠11: ILLEGAL (class 7, `reg_write`=0), subject to the parameter.
- **Destination.** `reg_write_o` is additionally forced to 0 when `rd`=0. `rd_o`=`instr[11:7]` always.

Optional Feature:
- **Macro:** `DECODE_SKID_BUFFER_EN`.
- **Enabled:** adds a 1-entry skid buffer holding a full decoded micro-op.
  - `input_ready_o` = `rst_ni` && !`skid_valid`, driven from a register with no combinational path from `output_ready_i`.
  - An accept while the output is stalled writes the skid buffer.
  - On the next output handshake the skid entry moves to the output and the skid buffer empties.
  - `flush_i` and reset clear the skid buffer.
  - Ordering is preserved.
- **Disabled:** no skid buffer; `input_ready_o` is as in Behaviour.

Test Plan:
1. **Basic accept.** Reset 2 cycles, then `instr_i`=0x00500093 (ADDI x1,x0,5), `pc_i`=0x1000, valid 1 cycle, `output_ready_i`=1 → next cycle: `output_valid_o`=1, `class`=0, `op1`=0, `op2`=5, `rd`=1, `reg_write`=1, `pc_o`=0x1000.
2. **Register operands.** 0x402081B3 (SUB x3,x1,x2) with `rdata1`=10, `rdata2`=3 → `raddr1`=1, `raddr2`=2 same cycle; next cycle `alu_op`=000, `alu_alt`=1, `op1`=10, `op2`=3, `rd`=3.
3. **Branch immediate.** 0xFE208CE3 (BEQ x1,x2,-8) → `class`=3, `imm`=0xFFFFFFF8, `reg_write`=0.
4. **Stall.** Valid output with `output_ready_i`=0 for 3 cycles and a new valid input → outputs unchanged, `input_ready_o`=0 (1 with skid until the buffer fills); `ready`=1 → the second micro-op appears the following cycle.
5. **Flush and reset.** `flush_i` pulse while `output_valid_o`=1 and input accepted → `output_valid_o`=0 next cycle and the accepted instr never emitted; `rst_ni`=0 mid-stall → all outputs 0 next cycle.
6. **Illegal.** `instr`=0x00000000 → `class`=7, `reg_write`=0 (param=1); with param=0 → `class`=0, `reg_write`=0.
